// File: rtl/mem_rr_arbiter_pkg.sv
// Shared definitions for the round-robin memory port arbiter: FSM state
// encoding, default timeout / error-data constants and bus width constants.
package mem_rr_arbiter_pkg;

  // Native memory bus widths (picorv32 mem_* interface)
  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  // Defaults for the forced-completion path
  localparam int               DEF_TIMEOUT   = 255;
  localparam logic [WORD_W-1:0] DEF_ERR_RDATA = 32'h0000_0000;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage : mem_rr_arbiter_pkg

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin find-first: returns the first set request bit
// scanning upward from ptr with wrap; ptr itself has top priority.
module mem_rr_arbiter_rr_pick #(
  parameter int N    = 2,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  logic            any_s;
  logic [ID_W-1:0] idx_s;
  logic [ID_W-1:0] cand_s;
  logic            hit_s;

  // Walk the N candidates in priority order, keeping the first hit
  always_comb begin
    any_s  = 1'b0;
    idx_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand_s = ID_W'((32'(ptr) + 32'(i)) % 32'(N));
      hit_s  = req[cand_s] & ~any_s;
      idx_s  = hit_s ? cand_s : idx_s;
      any_s  = any_s | req[cand_s];
    end
  end

  assign any = any_s;
  assign idx = idx_s;

endmodule : mem_rr_arbiter_rr_pick

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one downstream memory/IO port between N_CORES
// picorv32 native memory interfaces. One registered transaction at a time,
// with a per-transaction timeout that force-completes unanswered accesses.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int               N_CORES   = 2,
  parameter int               ID_W      = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  parameter int               TIMEOUT   = DEF_TIMEOUT,
  parameter logic [WORD_W-1:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          req_valid,
  input  logic [WORD_W*N_CORES-1:0]   req_addr,
  input  logic [WORD_W*N_CORES-1:0]   req_wdata,
  input  logic [STRB_W*N_CORES-1:0]   req_wstrb,
  output logic [N_CORES-1:0]          req_ready,
  output logic [WORD_W*N_CORES-1:0]   req_rdata,
  output logic                        dn_valid,
  output logic [WORD_W-1:0]           dn_addr,
  output logic [WORD_W-1:0]           dn_wdata,
  output logic [STRB_W-1:0]           dn_wstrb,
  input  logic                        dn_ready,
  input  logic [WORD_W-1:0]           dn_rdata,
  output logic [ID_W-1:0]             grant_id,
  output logic                        timeout_err
);

  // Last timer value before a transaction is forced to complete
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);
  // Highest core index; the pointer wraps to zero after it
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_CORES - 1);

  arb_state_e          state_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     grant_r;
  logic [15:0]         timer_r;
  logic                dn_valid_r;
  logic [WORD_W-1:0]   dn_addr_r;
  logic [WORD_W-1:0]   dn_wdata_r;
  logic [STRB_W-1:0]   dn_wstrb_r;
  logic [N_CORES-1:0]  req_ready_r;
  logic                timeout_err_r;
  logic [WORD_W-1:0]   rdata_r [N_CORES];

  logic [WORD_W-1:0]   addr_arr_s  [N_CORES];
  logic [WORD_W-1:0]   wdata_arr_s [N_CORES];
  logic [STRB_W-1:0]   wstrb_arr_s [N_CORES];
  logic [N_CORES-1:0]  grant_oh_s;
  logic                pick_any_s;
  logic [ID_W-1:0]     pick_idx_s;

  mem_rr_arbiter_rr_pick #(
    .N    (N_CORES),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Split the flat per-core request buses into indexable words
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      addr_arr_s[i]  = req_addr[WORD_W*i +: WORD_W];
      wdata_arr_s[i] = req_wdata[WORD_W*i +: WORD_W];
      wstrb_arr_s[i] = req_wstrb[STRB_W*i +: STRB_W];
    end
  end

  // One-hot form of the current grant, used for the ready pulse
  always_comb begin
    grant_oh_s = '0;
    for (int i = 0; i < N_CORES; i++) begin
      grant_oh_s[i] = (grant_r == ID_W'(i));
    end
  end

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= '0;
      grant_r       <= '0;
      timer_r       <= 16'd0;
      dn_valid_r    <= 1'b0;
      dn_addr_r     <= '0;
      dn_wdata_r    <= '0;
      dn_wstrb_r    <= '0;
      req_ready_r   <= '0;
      timeout_err_r <= 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
        rdata_r[i] <= '0;
      end
    end else begin
      // Ready and timeout are single-cycle pulses unless set below
      req_ready_r   <= '0;
      timeout_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            grant_r    <= pick_idx_s;
            dn_addr_r  <= addr_arr_s[pick_idx_s];
            dn_wdata_r <= wdata_arr_s[pick_idx_s];
            dn_wstrb_r <= wstrb_arr_s[pick_idx_s];
            dn_valid_r <= 1'b1;
            timer_r    <= 16'd0;
            state_r    <= ST_BUSY;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          timer_r <= timer_r + 16'd1;
          if (dn_ready) begin
            // A real answer always wins, even on the last timer cycle
            if (dn_wstrb_r == 4'b0000) begin
              rdata_r[grant_r] <= dn_rdata;
            end
            req_ready_r <= grant_oh_s;
            dn_valid_r  <= 1'b0;
            state_r     <= ST_RESP;
          end else if (timer_r == TMO_LAST) begin
            if (dn_wstrb_r == 4'b0000) begin
              rdata_r[grant_r] <= ERR_RDATA;
            end
            req_ready_r   <= grant_oh_s;
            timeout_err_r <= 1'b1;
            dn_valid_r    <= 1'b0;
            state_r       <= ST_RESP;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_RESP: begin
          // Pulse cycle gives the core time to drop mem_valid before re-arbitration
          rr_ptr_r <= (grant_r == LAST_ID) ? '0 : grant_r + ID_W'(1);
          state_r  <= ST_IDLE;
        end
        default: begin
          dn_valid_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Flatten the per-core read data registers onto the output bus
  always_comb begin
    req_rdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      req_rdata[WORD_W*i +: WORD_W] = rdata_r[i];
    end
  end

  assign req_ready   = req_ready_r;
  assign dn_valid    = dn_valid_r;
  assign dn_addr     = dn_addr_r;
  assign dn_wdata    = dn_wdata_r;
  assign dn_wstrb    = dn_wstrb_r;
  assign grant_id    = grant_r;
  assign timeout_err = timeout_err_r;

endmodule : mem_rr_arbiter
